// File: rtl/toy_mem_responder.sv
// Memory responder for the RISC_TOY core: one shared word array with fetch and data ports.
// Optional MEM_ACCESS_CNT_EN macro adds FETCH_CNT / RD_CNT / WR_CNT access counters.
module toy_mem_responder #(
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned ERR_W  = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              IREQ,
  input  logic [29:0]       IADDR,
  output logic [31:0]       INSTR,
  output logic              IVALID,
  input  logic              DREQ,
  input  logic              DRW,
  input  logic [29:0]       DADDR,
  input  logic [31:0]       DWDATA,
  output logic [31:0]       DRDATA,
  output logic              DVALID,
  input  logic              LD_WE,
  input  logic [29:0]       LD_ADDR,
  input  logic [31:0]       LD_DATA,
`ifdef MEM_ACCESS_CNT_EN
  output logic [31:0]       FETCH_CNT,
  output logic [31:0]       RD_CNT,
  output logic [31:0]       WR_CNT,
`endif
  output logic [ERR_W-1:0]  ERRCNT
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [ERR_W:0] ErrMax = {1'b0, {ERR_W{1'b1}}};

  if (RD_LAT == 0 || RD_LAT > 4) begin : gen_bad_rd_lat
    $error("RD_LAT must be within 1..4");
  end
  if (DEPTH < 16 || (DEPTH & (DEPTH - 1)) != 0) begin : gen_bad_depth
    $error("DEPTH must be a power of two and at least 16");
  end

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] i_idx, d_idx, ld_idx;
  logic          i_ok, d_ok, ld_ok;
  logic          d_rd, d_wr_commit, ld_commit;
  logic          i_err, d_err;
  logic [31:0]   i_rdata, d_rdata;

  assign i_idx  = IADDR[AW-1:0];
  assign d_idx  = DADDR[AW-1:0];
  assign ld_idx = LD_ADDR[AW-1:0];
  assign i_ok   = {2'b00, IADDR} < 32'(DEPTH);
  assign d_ok   = {2'b00, DADDR} < 32'(DEPTH);
  assign ld_ok  = {2'b00, LD_ADDR} < 32'(DEPTH);

  assign d_rd        = DREQ & ~DRW;
  // A backdoor load wins the array write port; the colliding data write is rejected.
  assign d_wr_commit = DREQ & DRW & d_ok & ~LD_WE;
  assign ld_commit   = LD_WE & ld_ok;

  assign i_err = IREQ & ~i_ok;
  assign d_err = DREQ & (~d_ok | (DRW & LD_WE));

  assign i_rdata = i_ok ? mem[i_idx] : 32'd0;
  assign d_rdata = d_ok ? mem[d_idx] : 32'd0;

  // Array contents are deliberately not reset.
  always_ff @(posedge CLK) begin
    if (ld_commit) begin
      mem[ld_idx] <= LD_DATA;
    end else if (d_wr_commit) begin
      mem[d_idx] <= DWDATA;
    end
  end

  // Per-port {valid, data} delay line; a stage only loads data when valid arrives,
  // so the last stage doubles as the hold register for INSTR/DRDATA.
  logic        i_v_q [RD_LAT];
  logic [31:0] i_d_q [RD_LAT];
  logic        d_v_q [RD_LAT];
  logic [31:0] d_d_q [RD_LAT];

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int s = 0; s < int'(RD_LAT); s++) begin
        i_v_q[s] <= 1'b0;
        i_d_q[s] <= 32'd0;
        d_v_q[s] <= 1'b0;
        d_d_q[s] <= 32'd0;
      end
    end else begin
      i_v_q[0] <= IREQ;
      d_v_q[0] <= d_rd;
      if (IREQ) i_d_q[0] <= i_rdata;
      if (d_rd) d_d_q[0] <= d_rdata;
      for (int s = 1; s < int'(RD_LAT); s++) begin
        i_v_q[s] <= i_v_q[s-1];
        d_v_q[s] <= d_v_q[s-1];
        if (i_v_q[s-1]) i_d_q[s] <= i_d_q[s-1];
        if (d_v_q[s-1]) d_d_q[s] <= d_d_q[s-1];
      end
    end
  end

  assign IVALID = i_v_q[RD_LAT-1];
  assign INSTR  = i_d_q[RD_LAT-1];
  assign DVALID = d_v_q[RD_LAT-1];
  assign DRDATA = d_d_q[RD_LAT-1];

  logic [ERR_W-1:0] err_q, err_d;
  logic [1:0]       err_inc;
  logic [ERR_W:0]   err_sum;

  always_comb begin
    err_inc = {1'b0, i_err} + {1'b0, d_err};
    err_sum = {1'b0, err_q} + (ERR_W + 1)'(err_inc);
    err_d   = (err_sum > ErrMax) ? ErrMax[ERR_W-1:0] : err_sum[ERR_W-1:0];
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      err_q <= '0;
    end else begin
      err_q <= err_d;
    end
  end

  assign ERRCNT = err_q;

`ifdef MEM_ACCESS_CNT_EN
  logic [31:0] fetch_cnt_q, rd_cnt_q, wr_cnt_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      fetch_cnt_q <= 32'd0;
      rd_cnt_q    <= 32'd0;
      wr_cnt_q    <= 32'd0;
    end else begin
      if (IREQ && i_ok) fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (d_rd && d_ok) rd_cnt_q    <= rd_cnt_q + 32'd1;
      if (d_wr_commit)  wr_cnt_q    <= wr_cnt_q + 32'd1;
    end
  end

  assign FETCH_CNT = fetch_cnt_q;
  assign RD_CNT    = rd_cnt_q;
  assign WR_CNT    = wr_cnt_q;
`endif

endmodule

// File: tb/tb_toy_mem_responder.sv
// Scoreboard bench for toy_mem_responder: three instances (RD_LAT 1, 3, 4) share one stimulus.
// Expected returns are queued at issue time and popped by a negedge monitor.
module tb_toy_mem_responder;

  localparam int NDUT = 3;

  typedef struct packed {
    logic [31:0] d;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ireq = 1'b0, dreq = 1'b0, drw = 1'b0, ld_we = 1'b0;
  logic [29:0] iaddr = '0, daddr = '0, ld_addr = '0;
  logic [31:0] dwdata = '0, ld_data = '0;

  logic [31:0] instr  [NDUT];
  logic [31:0] drdata [NDUT];
  logic        ivalid [NDUT];
  logic        dvalid [NDUT];
  logic [7:0]  errcnt [NDUT];
`ifdef MEM_ACCESS_CNT_EN
  logic [31:0] fetch_cnt [NDUT];
  logic [31:0] rd_cnt    [NDUT];
  logic [31:0] wr_cnt    [NDUT];
`endif

  exp_t        iq [NDUT][$];
  exp_t        dq [NDUT][$];
  logic [31:0] last_i [NDUT];
  logic [31:0] last_d [NDUT];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic        rst_s = 1'b1;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_s <= rst;
  end

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int unsigned LAT = (g == 0) ? 1 : ((g == 1) ? 3 : 4);
    toy_mem_responder #(
      .DEPTH  (1024),
      .RD_LAT (LAT),
      .ERR_W  (8)
    ) u_dut (
      .CLK       (clk),
      .RST       (rst),
      .IREQ      (ireq),
      .IADDR     (iaddr),
      .INSTR     (instr[g]),
      .IVALID    (ivalid[g]),
      .DREQ      (dreq),
      .DRW       (drw),
      .DADDR     (daddr),
      .DWDATA    (dwdata),
      .DRDATA    (drdata[g]),
      .DVALID    (dvalid[g]),
      .LD_WE     (ld_we),
      .LD_ADDR   (ld_addr),
      .LD_DATA   (ld_data),
`ifdef MEM_ACCESS_CNT_EN
      .FETCH_CNT (fetch_cnt[g]),
      .RD_CNT    (rd_cnt[g]),
      .WR_CNT    (wr_cnt[g]),
`endif
      .ERRCNT    (errcnt[g])
    );
  end

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 3 : 4);
  endfunction

  task automatic check(input string name, input int k, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d(lat%0d) got %h expected %h at cycle %0d",
               name, k, lat_of(k), act, exp, cyc);
    end
  endtask

  // Monitor: every returned word must match the oldest queued expectation with exact latency.
  always @(negedge clk) begin : mon
    exp_t e;
    for (int k = 0; k < NDUT; k++) begin
      if (rst_s) begin
        check("rst_ivalid", k, 32'(ivalid[k]), 32'd0);
        check("rst_instr", k, instr[k], 32'd0);
        check("rst_dvalid", k, 32'(dvalid[k]), 32'd0);
        check("rst_drdata", k, drdata[k], 32'd0);
        last_i[k] = 32'd0;
        last_d[k] = 32'd0;
      end else begin
        if (ivalid[k]) begin
          if (iq[k].size() == 0) begin
            check("ivalid_unexpected", k, 32'(ivalid[k]), 32'd0);
          end else begin
            e = iq[k].pop_front();
            check("instr", k, instr[k], e.d);
            check("ilatency", k, 32'(cyc - e.cyc), 32'(lat_of(k)));
            last_i[k] = e.d;
          end
        end else begin
          check("instr_hold", k, instr[k], last_i[k]);
        end
        if (dvalid[k]) begin
          if (dq[k].size() == 0) begin
            check("dvalid_unexpected", k, 32'(dvalid[k]), 32'd0);
          end else begin
            e = dq[k].pop_front();
            check("drdata", k, drdata[k], e.d);
            check("dlatency", k, 32'(cyc - e.cyc), 32'(lat_of(k)));
            last_d[k] = e.d;
          end
        end else begin
          check("drdata_hold", k, drdata[k], last_d[k]);
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    ireq  = 1'b0;
    dreq  = 1'b0;
    drw   = 1'b0;
    ld_we = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic fetch(input logic [29:0] a, input logic [31:0] exp);
    exp_t e;
    ireq  = 1'b1;
    iaddr = a;
    e.d   = exp;
    e.cyc = cyc;
    for (int k = 0; k < NDUT; k++) iq[k].push_back(e);
  endtask

  task automatic dread(input logic [29:0] a, input logic [31:0] exp);
    exp_t e;
    dreq  = 1'b1;
    drw   = 1'b0;
    daddr = a;
    e.d   = exp;
    e.cyc = cyc;
    for (int k = 0; k < NDUT; k++) dq[k].push_back(e);
  endtask

  task automatic dwrite(input logic [29:0] a, input logic [31:0] d);
    dreq   = 1'b1;
    drw    = 1'b1;
    daddr  = a;
    dwdata = d;
  endtask

  task automatic load(input logic [29:0] a, input logic [31:0] d);
    ld_we   = 1'b1;
    ld_addr = a;
    ld_data = d;
  endtask

  task automatic chk_err(input string name, input logic [7:0] exp);
    for (int k = 0; k < NDUT; k++) check(name, k, 32'(errcnt[k]), 32'(exp));
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin : stim
    repeat (2) @(negedge clk);
    chk_err("errcnt_reset", 8'd0);
    rst = 1'b0;

    // Preload
    load(30'd0, 32'h0800_0001); tick();
    load(30'd1, 32'h1111_2222); tick();
    load(30'd5, 32'hDEAD_BEEF); tick();
    load(30'd7, 32'hAAAA_AAAA); tick();
    load(30'd9, 32'h0000_0009); tick();

    // Back-to-back fetches
    fetch(30'd0, 32'h0800_0001); tick();
    fetch(30'd1, 32'h1111_2222); tick();
    idle(2);

    // Data read latency and hold
    dread(30'd5, 32'hDEAD_BEEF); tick();
    idle(5);

    // Same-edge write vs read returns the old word on both ports
    dwrite(30'd7, 32'h5555_5555); fetch(30'd7, 32'hAAAA_AAAA); tick();
    fetch(30'd7, 32'h5555_5555); tick();
    load(30'd9, 32'h9090_9090); dread(30'd9, 32'h0000_0009); tick();
    dread(30'd9, 32'h9090_9090); tick();
    idle(5);
    chk_err("errcnt_clean", 8'd0);

    // Out-of-range accesses
    dread(30'd1024, 32'd0); tick();
    chk_err("errcnt_oor_read", 8'd1);
    fetch(30'd2000, 32'd0); dwrite(30'd4000, 32'hCAFE_F00D); tick();
    chk_err("errcnt_oor_pair", 8'd3);

    // Backdoor load beats a same-cycle data write
    load(30'd3, 32'h1234_5678); dwrite(30'd3, 32'hFFFF_FFFF); tick();
    chk_err("errcnt_ld_prio", 8'd4);
    load(30'd1027, 32'hBAD0_BAD0); tick();
    chk_err("errcnt_ld_oor", 8'd4);
    dread(30'd3, 32'h1234_5678); tick();
    idle(5);

    // Saturation, including a +2 step from 254
    for (int i = 0; i < 125; i++) begin
      fetch(30'd2000, 32'd0); dread(30'd3000, 32'd0); tick();
    end
    chk_err("errcnt_254", 8'd254);
    fetch(30'd2000, 32'd0); dread(30'd3000, 32'd0); tick();
    chk_err("errcnt_sat", 8'd255);
    for (int i = 0; i < 3; i++) begin
      fetch(30'd2000, 32'd0); dread(30'd3000, 32'd0); tick();
    end
    chk_err("errcnt_stick", 8'd255);
    idle(6);

    // Reset while reads are in flight
    fetch(30'd0, 32'h0800_0001); tick();
    tick();
    rst = 1'b1;
    for (int k = 0; k < NDUT; k++) begin
      iq[k].delete();
      dq[k].delete();
    end
    ireq  = 1'b1;
    iaddr = 30'd1;
    tick();
    rst = 1'b0;
    chk_err("errcnt_after_rst", 8'd0);
    for (int k = 0; k < NDUT; k++) check("instr_after_rst", k, instr[k], 32'd0);

    fetch(30'd1, 32'h1111_2222); dread(30'd7, 32'h5555_5555); tick();
    fetch(30'd0, 32'h0800_0001); tick();
    idle(8);
    chk_err("errcnt_final", 8'd0);
`ifdef MEM_ACCESS_CNT_EN
    for (int k = 0; k < NDUT; k++) begin
      check("fetch_cnt", k, fetch_cnt[k], 32'd2);
      check("rd_cnt", k, rd_cnt[k], 32'd1);
      check("wr_cnt", k, wr_cnt[k], 32'd0);
    end
`endif

    for (int k = 0; k < NDUT; k++) begin
      check("ipending", k, 32'(iq[k].size()), 32'd0);
      check("dpending", k, 32'(dq[k].size()), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/toy_mem_responder.md
Name: toy_mem_responder

Overview:
- Memory-side responder for the RISC_TOY core's instruction port (IREQ/IADDR/INSTR) and data port (DREQ/DRW/DADDR/DWDATA/DRDATA).
- Harvard-style block: one word-addressed storage array with an independent fetch read path and a data read/write path.
- Read latency is fixed and programmable, fully pipelined, and there is no stall signal.
- A backdoor load port lets the bench preload program and data words; status outputs flag returns and out-of-range accesses.

Parameters:
- DEPTH, 1024, number of 32-bit words in the array; must be a power of two, at least 16.
- RD_LAT, 1, read latency in cycles from request to data on INSTR/DRDATA; legal range 1..4.
- ERR_W, 8, width of the saturating error counter.

Ports:
- CLK  in  1  clock; everything is rising-edge.
- RST  in  1  synchronous active-high reset.
- IREQ  in  1  fetch request.
- IADDR  in  30  fetch word address.
- INSTR  out  32  fetch return data.
- IVALID  out  1  one-cycle strobe when INSTR is updated.
- DREQ  in  1  data request.
- DRW  in  1  1 = write, 0 = read.
- DADDR  in  30  data word address.
- DWDATA  in  32  write data.
- DRDATA  out  32  data read return.
- DVALID  out  1  one-cycle strobe when DRDATA is updated.
- LD_WE  in  1  backdoor write enable.
- LD_ADDR  in  30  backdoor word address.
- LD_DATA  in  32  backdoor write data.
- ERRCNT  out  ERR_W  saturating count of rejected accesses.

Behaviour:
- Clock and reset: single clock CLK; reset RST is synchronous and active-high.
- Reset values: INSTR=0, DRDATA=0, IVALID=0, DVALID=0, ERRCNT=0. All in-flight read pipeline stages are cleared. Array contents are NOT reset.
- Reset mid-operation: reads issued before or during the RST cycle never return; the first new request accepted is the one sampled on the first cycle after RST deasserts.
- Address check: an address is in range iff ADDR < DEPTH; the index is ADDR[log2(DEPTH)-1:0].
- Fetch path:
  - IREQ=1 sampled at edge N launches a read.
  - At edge N+RD_LAT-1 (i.e. RD_LAT cycles after the request cycle), INSTR takes the word and IVALID pulses for one cycle.
  - One request is accepted per cycle, back-to-back, with no bubbles.
  - INSTR holds its last value while no return is due.
- Data read: DREQ=1, DRW=0 follows the same timing, returning on DRDATA and DVALID.
- Data write (DREQ=1, DRW=1):
  - The array word is updated at the request edge.
  - No DVALID pulse and DRDATA is unchanged.
- Read vs write ordering:
  - A read sampled on the same edge as a write to the same address returns the OLD word (read-before-write); this applies to both ports.
  - A read one or more cycles later returns the new word.
- Backdoor load: LD_WE=1 writes LD_DATA at the edge if LD_ADDR is in range; out-of-range loads are ignored silently.
- LD_WE and DREQ write in the same cycle: LD_WE has priority. The DREQ write is discarded (whatever the address) and counted in ERRCNT. Reads are unaffected by LD_WE.
- Out-of-range accesses:
  - Read: returns 0 with the normal latency and strobe, and increments ERRCNT.
  - Write: discarded, and increments ERRCNT.
  - Simultaneous out-of-range I and D accesses add 2 in that cycle.
- ERRCNT saturates at 2^ERR_W-1 and is cleared only by RST.
- Latency pipeline:
  - Implemented as an RD_LAT-deep shift of {valid, data} per port.
  - The array read is registered in stage 1; later stages are pure delay.
- Illegal RD_LAT: an illegal value is a compile-time error (generate-time check).

Optional Feature:
- MEM_ACCESS_CNT_EN.
- When defined, three extra outputs exist:
  - FETCH_CNT (32): accepted fetches.
  - RD_CNT (32): accepted data reads.
  - WR_CNT (32): committed data writes.
- Counter rules: counters wrap modulo 2^32 and clear on RST; rejected or out-of-range accesses are not counted; backdoor loads are not counted.
- When undefined, these ports and counters do not exist and the behaviour is otherwise identical.

Test Plan:
1. Preload: LD_WE writes 0x0800_0001 at address 0 and 0x1111_2222 at address 1. With RD_LAT=1, fetch IADDR=0 then IADDR=1 on consecutive cycles -> INSTR=0x0800_0001 then 0x1111_2222 on the following consecutive cycles, IVALID high for both.
2. RD_LAT=3: DREQ read of address 5 (preloaded 0xDEAD_BEEF) -> DRDATA=0xDEAD_BEEF and DVALID exactly 3 cycles later; DRDATA unchanged in between.
3. Same-cycle hazard: address 7 holds 0xAAAA_AAAA. DREQ write of 0x5555_5555 to address 7 with IREQ fetch of address 7 in the same cycle -> INSTR=0xAAAA_AAAA. A fetch of address 7 on the next cycle -> 0x5555_5555.
4. Out of range (DEPTH=1024): DADDR=1024 read -> DRDATA=0, DVALID=1, ERRCNT=1. Simultaneous IADDR=2000 fetch and DADDR=4000 write -> ERRCNT=3. Repeated violations -> ERRCNT sticks at 255.
5. Priority: LD_WE to address 3 with 0x1234_5678 and a DREQ write to address 3 with 0xFFFF_FFFF in the same cycle -> a later read returns 0x1234_5678 and ERRCNT increments by 1.
6. Reset mid-flight: RD_LAT=4, issue a fetch, assert RST two cycles later -> no IVALID pulse ever; INSTR=0 and ERRCNT=0 after reset. Array contents survive the reset and are readable afterwards.
